axis_packetizer: RTL and testbench

Parametrised successor to the sensor-stream packetizer: accepts a free-running word stream qualified by `valid` and emits fixed-length AXI4-Stream packets with `m_tlast` on the final beat. Unlike the earlier fixed 8-word, 32-bit block, it runs on a single ungated clock, buffers through a FIFO, honours `m_tready` backpressure, can flush a partial packet on request, and reports drops. Sits between the gyro HSI word assembler and the AXI-Stream DMA input.

---
 rtl/axis_packetizer_pkg.sv | 16 +
 rtl/packetizer_fifo.sv | 51 +++++
 rtl/axis_packetizer.sv | 115 +++++++++++
 tb/tb_axis_packetizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packetizer_pkg.sv
// Shared types and constants for the AXI-Stream packetizer.
package axis_packetizer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DROP_CNT_W = 16;

  // Occupancy needs one bit more than the pointers so full and empty differ.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/packetizer_fifo.sv
// Synchronous flop-array FIFO; the head word is presented combinationally.
module packetizer_fifo
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = level_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Packs a non-stallable word stream into fixed-length AXI-Stream packets,
// with flush of partial packets and sticky drop reporting.
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned DEPTH   = 16,
  localparam int unsigned LW = level_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  valid,
  input  logic                  flush,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clear_ovf
);

  state_t          state;
  logic [LW-1:0]   beats;
  logic            flush_pend;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic            hs;

  assign push = valid && enable && !full;
  assign drop = valid && enable && full;
  assign hs   = m_tvalid && m_tready;
  assign pop  = hs && !empty;

  packetizer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (data_in),
    .dout    (m_tdata),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Packet FSM; a new flush request in the launch cycle is kept pending.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      beats      <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (level >= LW'(PKT_LEN)) begin
            state      <= SEND;
            beats      <= LW'(PKT_LEN);
            m_tvalid   <= 1'b1;
            m_tlast    <= 1'b0;
            flush_pend <= flush;
          end else if (flush_pend) begin
            flush_pend <= flush;
            if (level != '0) begin
              state    <= SEND;
              beats    <= level;
              m_tvalid <= 1'b1;
              m_tlast  <= (level == LW'(1));
            end
          end
        end
        SEND: begin
          if (hs) begin
            beats   <= beats - LW'(1);
            m_tlast <= (beats == LW'(2));
            if (beats == LW'(1)) begin
              state    <= IDLE;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; clear beats a same-cycle drop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: default build plus a PKT_LEN=4/DEPTH=8 build.
module tb_axis_packetizer;

  typedef logic [32:0] beat_t;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        flush;
  logic        clear_ovf;

  logic [31:0] data_in;
  logic        valid;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic [15:0] data4;
  logic        valid4;
  logic [15:0] m_tdata4;
  logic        m_tvalid4;
  logic        m_tready4;
  logic        m_tlast4;
  logic [3:0]  level4;
  logic        overflow4;
  logic [15:0] drop_cnt4;

  int errors = 0;
  int checks = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;
  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t got4_q[$];
  beat_t exp4_q[$];

  axis_packetizer dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .valid(valid), .flush(flush), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
  );

  axis_packetizer #(.DATA_W(16), .PKT_LEN(4), .DEPTH(8)) dut4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data4),
    .valid(valid4), .flush(flush), .m_tdata(m_tdata4), .m_tvalid(m_tvalid4),
    .m_tready(m_tready4), .m_tlast(m_tlast4), .level(level4), .overflow(overflow4),
    .drop_cnt(drop_cnt4), .clear_ovf(clear_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Beats are captured mid-cycle; a stalled beat must not change until accepted.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'(1));
        check("stall_data", 64'(m_tdata), 64'(prev_data));
      end
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (m_tvalid4 && m_tready4) got4_q.push_back({m_tlast4, 32'(m_tdata4)});
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic expect_pkt(input int first, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back({b == len - 1, 32'(first + b)});
  endtask

  task automatic compare_q(input string tag, input beat_t g[$], input beat_t e[$]);
    check({tag, "_beats"}, 64'(g.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(g[i]), 64'(e[i]));
  endtask

  task automatic wait_drain(input string tag, input bit toggle);
    int n = 0;
    while ((level != 0 || m_tvalid || level4 != 0 || m_tvalid4) && n < 400) begin
      if (toggle) m_tready = !m_tready;
      step();
      n++;
    end
    check({tag, "_drain"}, 64'(level == 0 && !m_tvalid && level4 == 0 && !m_tvalid4), 64'(1));
  endtask

  task automatic send_words(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      valid   = 1'b1;
      data_in = 32'(first + i);
      step();
    end
    valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0; clear_ovf = 1'b0;
    data_in = '0; valid = 1'b0; m_tready = 1'b0;
    data4 = '0; valid4 = 1'b0; m_tready4 = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));

    // Basic packet and two-cycle launch latency.
    m_tready = 1'b1;
    send_words(0, 8);
    check("t1_lat_before", 64'(m_tvalid), 64'(0));
    step();
    check("t1_lat_valid", 64'(m_tvalid), 64'(1));
    check("t1_first_data", 64'(m_tdata), 64'(0));
    wait_drain("t1", 0);
    expect_pkt(0, 8);
    compare_q("t1", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // 24 sequential words with ready toggling every cycle.
    m_tready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      valid = 1'b1; data_in = 32'('h100 + i); m_tready = !m_tready;
      step();
      valid = 1'b0; m_tready = !m_tready;
      step();
    end
    wait_drain("t2", 1);
    m_tready = 1'b1;
    check("t2_ovf", 64'(overflow), 64'(0));
    check("t2_drop", 64'(drop_cnt), 64'(0));
    for (int p = 0; p < 3; p++) expect_pkt('h100 + 8 * p, 8);
    compare_q("t2", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // Overflow with ready held low, then clear-vs-drop priority.
    m_tready = 1'b0;
    send_words('h200, 20);
    check("t3_level", 64'(level), 64'(16));
    check("t3_ovf", 64'(overflow), 64'(1));
    check("t3_drop", 64'(drop_cnt), 64'(4));
    valid = 1'b1; data_in = 32'h2FF; clear_ovf = 1'b1;
    step();
    check("t3_clrwin_ovf", 64'(overflow), 64'(0));
    check("t3_clrwin_drop", 64'(drop_cnt), 64'(0));
    clear_ovf = 1'b0;
    step();
    check("t3_redrop_ovf", 64'(overflow), 64'(1));
    check("t3_redrop_cnt", 64'(drop_cnt), 64'(1));
    valid = 1'b0; clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("t3_clr_ovf", 64'(overflow), 64'(0));
    check("t3_clr_drop", 64'(drop_cnt), 64'(0));
    m_tready = 1'b1;
    wait_drain("t3", 0);
    expect_pkt('h200, 8);
    expect_pkt('h208, 8);
    compare_q("t3", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // Flush of a 3-word partial packet, then flush with an empty FIFO.
    send_words('h300, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_lat0", 64'(m_tvalid), 64'(0));
    step();
    check("t4_flush_valid", 64'(m_tvalid), 64'(1));
    check("t4_flush_tlast0", 64'(m_tlast), 64'(0));
    wait_drain("t4", 0);
    expect_pkt('h300, 3);
    compare_q("t4", got_q, exp_q);
    got_q.delete(); exp_q.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    send_words('h3AA, 1);
    repeat (4) step();
    check("t4_empty_flush_level", 64'(level), 64'(1));
    check("t4_empty_flush_tvalid", 64'(m_tvalid), 64'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain("t4b", 0);
    expect_pkt('h3AA, 1);
    compare_q("t4b", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // Words are ignored, not dropped, while disabled.
    enable = 1'b0;
    send_words('h350, 3);
    check("en_level", 64'(level), 64'(0));
    check("en_drop", 64'(drop_cnt), 64'(0));
    enable = 1'b1;

    // Flush arriving during SEND is served after the current packet.
    send_words('h400, 10);
    check("t5_in_send", 64'(m_tvalid), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain("t5", 0);
    expect_pkt('h400, 8);
    expect_pkt('h408, 2);
    compare_q("t5", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // Reset while a packet is stalled on the bus.
    m_tready = 1'b0;
    send_words('h500, 8);
    step();
    check("t6_pre_tvalid", 64'(m_tvalid), 64'(1));
    reset_n = 1'b0;
    step();
    check("t6_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_tlast", 64'(m_tlast), 64'(0));
    check("t6_tdata", 64'(m_tdata), 64'(0));
    check("t6_level", 64'(level), 64'(0));
    reset_n = 1'b1;
    m_tready = 1'b1;
    send_words('h600, 8);
    wait_drain("t6", 0);
    expect_pkt('h600, 8);
    compare_q("t6", got_q, exp_q);
    got_q.delete(); exp_q.delete();

    // Small build: 12 words through an 8-deep FIFO wraps the pointers.
    for (int i = 0; i < 12; i++) begin
      valid4 = 1'b1;
      data4  = 16'('h7000 + i);
      step();
    end
    valid4 = 1'b0;
    wait_drain("t7", 0);
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++)
        exp4_q.push_back({b == 3, 32'('h7000 + 4 * p + b)});
    compare_q("t7", got4_q, exp4_q);
    check("t7_ovf", 64'(overflow4), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
